// File: rtl/fft8_controller_if.sv
// ----------------------------------------------------------------------------
// fft8_controller_if
// Groups the sample-in stream, the spectrum-out stream and the butterfly
// operand/result bus of the 8-point FFT sequencer.
//
// Signals:
//   in_valid / in_ready / in_data      : sample stream into the controller
//   out_valid / out_ready / out_data   : spectrum stream out of the controller
//   out_index                          : bin number of out_data
//   busy                               : controller is computing or unloading
//   bf_num1 / bf_num2                  : operands to the external butterfly
//   bf_twiddle_index                   : k of W8^k for the external butterfly
//   bf_result1 / bf_result2            : num1 + W*num2 / num1 - W*num2
//
// Modports:
//   slave  : the controller side
//   master : the environment side (sample source, result sink, butterfly)
// ----------------------------------------------------------------------------
interface fft8_controller_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_index;
    logic             busy;
    logic [WIDTH-1:0] bf_num1;
    logic [WIDTH-1:0] bf_num2;
    logic [2:0]       bf_twiddle_index;
    logic [WIDTH-1:0] bf_result1;
    logic [WIDTH-1:0] bf_result2;

    modport slave (
        input  in_valid, in_data, out_ready, bf_result1, bf_result2,
        output in_ready, out_valid, out_data, out_index, busy,
               bf_num1, bf_num2, bf_twiddle_index
    );

    modport master (
        output in_valid, in_data, out_ready, bf_result1, bf_result2,
        input  in_ready, out_valid, out_data, out_index, busy,
               bf_num1, bf_num2, bf_twiddle_index
    );
endinterface

// File: rtl/fft8_controller.sv
// ----------------------------------------------------------------------------
// fft8_controller
// Sequencer for an 8-point radix-2 DIT FFT. Loads one frame of eight packed
// complex samples in bit-reversed order, drives one external butterfly
// through 3 stages x 4 butterflies, then streams the spectrum out in natural
// order. Words pass unmodified between the buffer and the butterfly.
//
// Parameters:
//   N          : FFT length (only 8 is supported)
//   WIDTH      : sample width, {real[31:16], imag[15:0]}
//   BF_LATENCY : clock edges from a bf_* change to a valid bf_result* (>=1)
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fft8_controller_if.slave (streams + butterfly bus)
// ----------------------------------------------------------------------------
module fft8_controller #(
    parameter int N          = 8,
    parameter int WIDTH      = 32,
    parameter int BF_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fft8_controller_if.slave   bus
);

    localparam int WCW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_UNLOAD
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_buf [N];
    logic [2:0]       r_cnt;
    logic [2:0]       r_idx;
    logic [1:0]       r_s;
    logic [1:0]       r_k;
    logic [WCW-1:0]   r_wait;

    logic [WIDTH-1:0] r_bf_num1;
    logic [WIDTH-1:0] r_bf_num2;
    logic [2:0]       r_bf_tw;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_wait_done;
    logic             w_last_bf;
    logic [2:0]       w_load_addr;
    logic [2:0]       w_span;
    logic [2:0]       w_pos;
    logic [2:0]       w_i;
    logic [2:0]       w_j;
    logic [2:0]       w_tw;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;
    logic [WIDTH-1:0] w_out_data;

    // Handshakes are decoded from the state register directly so that the
    // next-state logic never depends on its own outputs.
    assign w_in_fire   = bus.in_valid  && (r_state == S_LOAD);
    assign w_out_fire  = bus.out_ready && (r_state == S_UNLOAD);
    assign w_wait_done = (r_wait == WCW'(BF_LATENCY - 1));
    assign w_last_bf   = (r_s == 2'd2) && (r_k == 2'd3);

    // Samples land in bit-reversed position so the DIT stages run in place.
    assign w_load_addr = {r_cnt[0], r_cnt[1], r_cnt[2]};

    // Butterfly addressing for stage s, butterfly k:
    //   span = 1<<s, pos = k & (span-1), i = ((k>>s)<<(s+1)) + pos, j = i+span
    //   twiddle = pos << (2-s)
    assign w_span = 3'd1 << r_s;
    assign w_pos  = {1'b0, r_k} & (w_span - 3'd1);
    assign w_i    = (({1'b0, r_k} >> r_s) << (r_s + 2'd1)) + w_pos;
    assign w_j    = w_i + w_span;
    assign w_tw   = w_pos << (2'd2 - r_s);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        w_out_data  = '0;
        case (r_state)
            S_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (w_in_fire && (r_cnt == 3'd7)) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_wait_done) begin
                    w_next = w_last_bf ? S_UNLOAD : S_ISSUE;
                end
            end
            S_UNLOAD: begin
                w_out_valid = 1'b1;
                w_out_data  = r_buf[r_idx];
                if (w_out_fire && (r_idx == 3'd7)) begin
                    w_next = S_LOAD;
                end
            end
            default: begin
                w_next = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the sample buffer is cleared on reset so an aborted frame
            // can never leak stale words into the next result.
            for (int n = 0; n < N; n++) begin
                r_buf[n] <= '0;
            end
            r_cnt     <= '0;
            r_idx     <= '0;
            r_s       <= '0;
            r_k       <= '0;
            r_wait    <= '0;
            r_bf_num1 <= '0;
            r_bf_num2 <= '0;
            r_bf_tw   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_buf[w_load_addr] <= bus.in_data;
                        r_cnt              <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_s <= '0;
                            r_k <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_bf_num1 <= r_buf[w_i];
                    r_bf_num2 <= r_buf[w_j];
                    r_bf_tw   <= w_tw;
                    r_wait    <= '0;
                end
                S_WAIT: begin
                    if (w_wait_done) begin
                        // Both halves of the butterfly are written back in
                        // the same edge; i and j are always distinct.
                        r_buf[w_i] <= bus.bf_result1;
                        r_buf[w_j] <= bus.bf_result2;
                        r_k        <= r_k + 2'd1;
                        if (r_k == 2'd3) begin
                            r_s <= w_last_bf ? 2'd0 : r_s + 2'd1;
                        end
                        if (w_last_bf) begin
                            r_idx <= '0;
                        end
                    end else begin
                        r_wait <= r_wait + WCW'(1);
                    end
                end
                S_UNLOAD: begin
                    if (w_out_fire) begin
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_cnt <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready         = w_in_ready;
    assign bus.out_valid        = w_out_valid;
    assign bus.out_data         = w_out_data;
    assign bus.out_index        = (r_state == S_UNLOAD) ? r_idx : 3'd0;
    assign bus.busy             = w_busy;
    assign bus.bf_num1          = r_bf_num1;
    assign bus.bf_num2          = r_bf_num2;
    assign bus.bf_twiddle_index = r_bf_tw;

endmodule

// File: tb/tb_fft8_controller.sv
// ----------------------------------------------------------------------------
// tb_fft8_controller
// Self-checking bench for fft8_controller. Provides a behavioural FP16
// complex butterfly (one internal register stage after the controller's
// registered operands), drives frames, checks the butterfly sequence against
// a fixed (i, j, twiddle) table and checks the unloaded spectrum through an
// expected-result queue.
// ----------------------------------------------------------------------------
module tb_fft8_controller;

    localparam int BF_LATENCY = 2;

    typedef logic [31:0] frame_t [8];
    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] data;
    } exp_t;

    localparam int BITREV [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    localparam int I_TBL  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    localparam int J_TBL  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    localparam int T_TBL  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    logic clk;
    logic rst_n;

    fft8_controller_if #(.WIDTH(32)) bus ();

    fft8_controller #(
        .N          (8),
        .WIDTH      (32),
        .BF_LATENCY (BF_LATENCY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    exp_t   exp_q [$];
    frame_t m_buf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- FP16 complex butterfly model ----------------
    function automatic real h2r(input logic [15:0] h);
        int  e;
        real v;
        e = int'(h[14:10]);
        if (e == 0) begin
            v = real'(h[9:0]) / 16777216.0;
        end else begin
            v = 1.0 + real'(h[9:0]) / 1024.0;
            for (int q = 15; q < e; q++) v = v * 2.0;
            for (int q = e; q < 15; q++) v = v / 2.0;
        end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic sgn;
        real  a;
        int   e;
        int   m;
        sgn = (r < 0.0);
        a   = sgn ? -r : r;
        e   = 15;
        if (a == 0.0) return 16'h0000;
        while (a >= 2.0 && e < 31) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > 1)   begin a = a * 2.0; e--; end
        if (e >= 31) return {sgn, 5'h1f, 10'h000};
        if (a < 1.0) begin
            m = int'(a * 1024.0);
            if (m >= 1024) return {sgn, 5'd1, 10'd0};
            if (m == 0) return 16'h0000;
            return {sgn, 5'd0, m[9:0]};
        end
        m = int'((a - 1.0) * 1024.0);
        if (m >= 1024) begin m = 0; e++; end
        if (e >= 31) return {sgn, 5'h1f, 10'h000};
        return {sgn, e[4:0], m[9:0]};
    endfunction

    // Returns {num1 + W*num2, num1 - W*num2}, W = e^(-j*2*pi*k/8).
    function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] k);
        real ar, ai, br, bi, wr, wi, pr, pi;
        ar = h2r(a[31:16]); ai = h2r(a[15:0]);
        br = h2r(b[31:16]); bi = h2r(b[15:0]);
        case (k)
            3'd1:    begin wr =  0.70710678118; wi = -0.70710678118; end
            3'd2:    begin wr =  0.0;           wi = -1.0;           end
            3'd3:    begin wr = -0.70710678118; wi = -0.70710678118; end
            default: begin wr =  1.0;           wi =  0.0;           end
        endcase
        pr = br * wr - bi * wi;
        pi = br * wi + bi * wr;
        return {r2h(ar + pr), r2h(ai + pi), r2h(ar - pr), r2h(ai - pi)};
    endfunction

    // External butterfly: one register stage after the registered operands.
    logic [31:0] r_res1;
    logic [31:0] r_res2;
    always @(posedge clk) begin
        {r_res1, r_res2} <= bfly(bus.bf_num1, bus.bf_num2, bus.bf_twiddle_index);
    end
    assign bus.bf_result1 = r_res1;
    assign bus.bf_result2 = r_res2;

    // Reference FFT built from the fixed sequence table.
    task automatic model_fft(input frame_t x, output frame_t y);
        frame_t      b;
        logic [63:0] rr;
        for (int n = 0; n < 8; n++) b[BITREV[n]] = x[n];
        for (int t = 0; t < 12; t++) begin
            rr = bfly(b[I_TBL[t]], b[J_TBL[t]], 3'(T_TBL[t]));
            b[I_TBL[t]] = rr[63:32];
            b[J_TBL[t]] = rr[31:0];
        end
        y = b;
    endtask

    // ---------------- stimulus / monitor tasks ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),         32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid),        32'd0);
        check({tag, "_out_data"},  bus.out_data,              32'd0);
        check({tag, "_out_index"}, 32'(bus.out_index),        32'd0);
        check({tag, "_busy"},      32'(bus.busy),             32'd0);
        check({tag, "_bf_num1"},   bus.bf_num1,               32'd0);
        check({tag, "_bf_num2"},   bus.bf_num2,               32'd0);
        check({tag, "_bf_tw"},     32'(bus.bf_twiddle_index), 32'd0);
    endtask

    task automatic load_frame(input frame_t x, input frame_t e, input bit gaps);
        int n     = 0;
        int guard = 0;
        bit hs;
        for (int q = 0; q < 8; q++) exp_q.push_back('{idx: 3'(q), data: e[q]});
        while (n < 8 && guard < 100) begin
            @(negedge clk);
            if (gaps && n > 0 && $urandom_range(2, 0) == 0) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = x[n];
            end
            check("load_in_ready", 32'(bus.in_ready), 32'd1);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (hs) begin
                m_buf[BITREV[n]] = x[n];
                n++;
            end
            guard++;
        end
        if (n < 8) check("load_timeout", n, 8);
    endtask

    task automatic compute(input bit poke_in, input int abort_c, output bit aborted);
        logic [31:0] h1, h2;
        logic [2:0]  ht;
        logic [63:0] rr;
        int          b, ph;
        aborted = 1'b0;
        h1 = '0; h2 = '0; ht = '0;
        @(negedge clk);
        bus.in_valid  = poke_in;
        bus.in_data   = $urandom;
        bus.out_ready = 1'b0;
        check("issue_in_ready", 32'(bus.in_ready),  32'd0);
        check("issue_busy",     32'(bus.busy),      32'd1);
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            bus.in_valid = poke_in;
            bus.in_data  = $urandom;
            if (c == abort_c) begin
                bus.in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                aborted = 1'b1;
                return;
            end
            b  = (c - 1) / 3;
            ph = (c - 1) % 3;
            if (ph == 0) begin
                check("bf_num1", bus.bf_num1, m_buf[I_TBL[b]]);
                check("bf_num2", bus.bf_num2, m_buf[J_TBL[b]]);
                check("bf_tw",   32'(bus.bf_twiddle_index), T_TBL[b]);
                check("cmp_in_ready", 32'(bus.in_ready), 32'd0);
                h1 = bus.bf_num1;
                h2 = bus.bf_num2;
                ht = bus.bf_twiddle_index;
            end else if (ph == 1) begin
                check("wait_num1_stable", bus.bf_num1, h1);
                check("wait_num2_stable", bus.bf_num2, h2);
                check("wait_tw_stable",   32'(bus.bf_twiddle_index), 32'(ht));
                rr = bfly(h1, h2, ht);
                m_buf[I_TBL[b]] = rr[63:32];
                m_buf[J_TBL[b]] = rr[31:0];
            end
            if (c == 35) check("out_valid_early", 32'(bus.out_valid), 32'd0);
            if (c == 36) begin
                check("out_valid_at_36", 32'(bus.out_valid), 32'd1);
                check("first_index",     32'(bus.out_index), 32'd0);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic unload(input int mode);
        int          got = 0;
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] sd = '0;
        logic [2:0]  si = '0;
        exp_t        e;
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 3 == 0);
                default: bus.out_ready = 1'($urandom_range(1, 0));
            endcase
            check("unload_valid", 32'(bus.out_valid), 32'd1);
            if (stalled) begin
                check("stall_data",  bus.out_data,          sd);
                check("stall_index", 32'(bus.out_index),    32'(si));
            end
            stalled = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_index", 32'(bus.out_index), 32'(e.idx));
                    check("out_data",  bus.out_data,       e.data);
                end
                got++;
            end else if (bus.out_valid) begin
                stalled = 1'b1;
                sd      = bus.out_data;
                si      = bus.out_index;
            end
            @(posedge clk);
            cyc++;
        end
        if (got < 8) check("unload_timeout", got, 8);
        if (mode == 0) check("unload_cycles", cyc, 8);
        #1;
        check("after_in_ready",  32'(bus.in_ready),  32'd1);
        check("after_out_valid", 32'(bus.out_valid), 32'd0);
        check("after_busy",      32'(bus.busy),      32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        frame_t f_imp, e_imp, f_dc, e_dc, f_rnd, e_rnd;
        bit     ab;
        int     vr, vi;

        for (int n = 0; n < 8; n++) begin
            f_imp[n] = (n == 0) ? 32'h3c000000 : 32'h0;
            e_imp[n] = 32'h3c000000;
            f_dc[n]  = 32'h3c000000;
            e_dc[n]  = (n == 0) ? 32'h48000000 : 32'h0;
            vr = int'($urandom_range(14, 0)) - 7;
            vi = int'($urandom_range(14, 0)) - 7;
            f_rnd[n] = {r2h(real'(vr)), r2h(real'(vi))};
        end
        model_fft(f_rnd, e_rnd);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Impulse, full rate, in_valid held high during compute.
        load_frame(f_imp, e_imp, 1'b0);
        compute(1'b1, 0, ab);
        unload(0);

        // DC frame straight after, with load gaps and 1,0,0 back-pressure.
        load_frame(f_dc, e_dc, 1'b1);
        compute(1'b0, 0, ab);
        unload(1);

        // Arbitrary frame against the reference FFT, random back-pressure.
        load_frame(f_rnd, e_rnd, 1'b1);
        compute(1'b1, 0, ab);
        unload(2);

        // Reset during stage-1 WAIT, then a clean impulse frame.
        load_frame(f_imp, e_imp, 1'b0);
        compute(1'b0, 17, ab);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_abort");
        load_frame(f_imp, e_imp, 1'b0);
        compute(1'b0, 0, ab);
        unload(0);

        check("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fft8_controller.md
# fft8_controller

Sequencer for the 8-point radix-2 DIT FFT. It accepts one frame of eight packed complex samples over a valid/ready stream and stores them in bit-reversed order. It then drives a single external `butterfly2p` instance through 3 stages × 4 butterflies and streams the eight spectrum words out in natural order. It sits between the sample source and the result sink, and owns the only sample buffer in the FFT.

## Interface
- `N`, 8: FFT length, fixed; values other than 8 are unsupported.
- `WIDTH`, 32: sample width, {real[31:16], imag[15:0]}, same packing as `butterfly2p`.
- `BF_LATENCY`, 2: clock edges from a `bf_*` input change to a valid `bf_result*`. Must be ≥1.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  controller accepts a sample.
- `in_data`  in  WIDTH  input sample, natural order x[0]..x[7].
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  sink accepts the output sample.
- `out_data`  out  WIDTH  spectrum word X[out_index].
- `out_index`  out  3  bin number, 0..7.
- `busy`  out  1  high in COMPUTE and UNLOAD.
- `bf_num1`, `bf_num2`  out  WIDTH  butterfly operands (registered).
- `bf_twiddle_index`  out  3  k selects W8^k = e^(-j2πk/8) (registered).
- `bf_result1`, `bf_result2`  in  WIDTH  butterfly outputs: num1+W·num2 and num1−W·num2.

## Operation
- Buffer: 8×WIDTH registers, all cleared on reset.
- FSM states are LOAD, ISSUE, WAIT and UNLOAD.
- LOAD:
  - `in_ready`=1.
  - Each handshake (`in_valid`&`in_ready`) writes `in_data` to buf[bitrev3(cnt)] and increments cnt.
  - After the 8th handshake, go to ISSUE with s=0, k=0.
- ISSUE, for stage s∈{0,1,2} and butterfly k∈{0..3}:
  - span=1<<s, pos=k&(span−1).
  - i=((k>>s)<<(s+1))+pos, j=i+span.
  - Register `bf_num1`=buf[i], `bf_num2`=buf[j] and `bf_twiddle_index`=pos<<(2−s).
  - Clear the wait counter and go to WAIT.
- WAIT:
  - `bf_*` outputs are held stable.
  - After BF_LATENCY cycles in WAIT, write buf[i]←`bf_result1` and buf[j]←`bf_result2` in the same edge.
  - Advance k, and at k=3 advance s.
  - After s=2,k=3, go to UNLOAD with idx=0; otherwise return to ISSUE.
- Index sequence, required exactly:
  - s0: pairs (0,1),(2,3),(4,5),(6,7), twiddle 0,0,0,0.
  - s1: pairs (0,2),(1,3),(4,6),(5,7), twiddle 0,2,0,2.
  - s2: pairs (0,4),(1,5),(2,6),(3,7), twiddle 0,1,2,3.
- UNLOAD:
  - `out_valid`=1, `out_data`=buf[idx], `out_index`=idx.
  - On `out_ready`, increment idx. After idx=7 is accepted, go to LOAD with cnt=0.
- No arithmetic inside the controller. Words pass unmodified between the buffer and the butterfly.

## Timing
- Reset values:
  - State=LOAD; `in_ready`=1.
  - `out_valid`=0, `out_data`=0, `out_index`=0, `busy`=0.
  - `bf_num1`=`bf_num2`=0, `bf_twiddle_index`=0.
  - All counters 0.
- Reset mid-operation, in any state, aborts the frame: the buffer is cleared, nothing partial is output, and the controller is back in LOAD on the first edge after `rst_n` rises.
- `in_ready` is 0 in ISSUE, WAIT and UNLOAD. `in_valid` is ignored there, and no sample is lost or stored.
- Load takes 8 cycles at full rate. Gaps in `in_valid` stall cnt.
- Each butterfly takes 1 ISSUE + BF_LATENCY WAIT cycles. Compute takes 12·(BF_LATENCY+1) cycles, which is 36 for the default.
- UNLOAD back-pressure:
  - `out_data` and `out_index` stay stable while `out_valid`&!`out_ready`.
  - With `out_ready` held at 1, unload takes 8 cycles.
- In the cycle the final word is accepted, `out_valid` stays 1. `in_ready` rises on the next edge. A new frame may begin on the cycle after that.
- `busy` is 1 from the edge entering ISSUE(s0,k0) through the edge leaving UNLOAD.

## Test plan
- Impulse: x=[0x3c000000,0×7], `out_ready`=1 → all eight outputs 0x3c000000; `out_index` 0..7; first `out_valid` exactly 36 cycles after the last input handshake.
- DC: eight × 0x3c000000 → X[0]=0x48000000 (8+0j), X[1..7]=0x00000000.
- Sequencing monitor: any frame → the 12 (i,j,twiddle) triples match the Operation list in order; `bf_*` are unchanged throughout each WAIT.
- Back-pressure: toggle `out_ready` 1,0,0,1… during UNLOAD → no word is dropped or duplicated, and data is stable while stalled; `in_valid`=1 during compute → `in_ready`=0 and the buffer is unaffected.
- Reset mid-compute: assert `rst_n`=0 during s1 WAIT → all outputs are at reset values immediately; the next impulse frame yields the correct all-0x3c000000 result.
- Back-to-back frames: the DC frame is fed immediately after the impulse frame unloads → both results are correct with no stale data.
